// File: rtl/alu_arbiter_if.sv
// Request/ALU/response bundle for alu_arbiter. master = requesters, ALU and response
// consumer side; slave = the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_opa;
  logic [NREQ*WIDTH-1:0] req_opb;
  logic [NREQ*4-1:0]     req_op;
  logic [WIDTH-1:0]      alu_opa;
  logic [WIDTH-1:0]      alu_opb;
  logic [3:0]            alu_opcode;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_opa, req_opb, req_op, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_opa, alu_opb, alu_opcode, rsp_valid, rsp_id,
           rsp_result, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_opa, req_opb, req_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_opa, alu_opb, alu_opcode, rsp_valid, rsp_id,
           rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters;
// one operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold result).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d, id_q, id_d;
  logic [IDW-1:0]   gnt, idx;
  logic             gnt_vld;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       op_q, op_d, sel_op;
  logic             zero_q, zero_d, err_q, err_d;

  function automatic logic op_legal(input logic [3:0] op);
    return !op[3] && (op != 4'b0110);
  endfunction

  function automatic logic op_shift(input logic [3:0] op);
    return (op == 4'b0101) || (op == 4'b0111);
  endfunction

  // First valid requester starting just after the last winner.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  assign sel_a  = bus.req_opa[int'(gnt)*WIDTH +: WIDTH];
  assign sel_b  = bus.req_opb[int'(gnt)*WIDTH +: WIDTH];
  assign sel_op = bus.req_op[int'(gnt)*4 +: 4];

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && gnt_vld) bus.req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        state_d = EXEC;
        last_d  = gnt;
        id_d    = gnt;
        opa_d   = sel_a;
        op_d    = sel_op;
        opb_d   = sel_b;
        if (op_shift(sel_op)) begin
          opb_d            = '0;
          opb_d[SHW-1:0]   = sel_b[SHW-1:0];
        end
      end
      EXEC: begin
        state_d = RESP;
        // Illegal opcodes never trust the ALU output.
        if (op_legal(op_q)) begin
          res_d  = bus.alu_result;
          zero_d = bus.alu_zero;
          err_d  = 1'b0;
        end else begin
          res_d  = '0;
          zero_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.alu_opa    = opa_q;
  assign bus.alu_opb    = opb_q;
  assign bus.alu_opcode = op_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, fairness and backpressure/reset
// sequences, then randomized traffic against a behavioural model.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment ALU: uses the full B so an unmasked shift amount shows up.
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b;
      4'd7: return a >> b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_opcode, bus.alu_opa, bus.alu_opb);
  assign bus.alu_zero   = (bus.alu_result == '0);

  int n_tests = 0;
  int n_fail  = 0;

  logic        pend [N];
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  logic [3:0]  po [N];
  int          last_m;
  logic [W-1:0] l_res, l_aob;
  logic        l_z, l_e;
  int          l_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = pend[i];
      bus.req_opa[i*W +: W]   = pa[i];
      bus.req_opb[i*W +: W]   = pb[i];
      bus.req_op[i*4 +: 4]    = po[i];
    end
  endtask

  // Reference semantics straight from the opcode table.
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, b,
                           output logic [W-1:0] r, output logic z, output logic e);
    int sh;
    sh = int'(b % W);
    e  = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd7: r = a >> sh;
      default: begin r = '0; e = 1'b1; end
    endcase
    z = (r == '0);
  endtask

  function automatic logic [W-1:0] exp_opb(input logic [3:0] op, input logic [W-1:0] b);
    return (op == 4'd5 || op == 4'd7) ? (b % W) : b;
  endfunction

  // One complete transaction starting from IDLE at a negedge; ends at a negedge in IDLE.
  task automatic xact(input int stall, output int g);
    logic [W-1:0] er;
    logic ez, ee;
    int lat;
    drive();
    #1;
    g = 0;
    for (int k = N; k >= 1; k--) if (pend[(last_m + k) % N]) g = (last_m + k) % N;
    chk("req_ready_grant", bus.req_ready, 64'(1 << g));
    chk("busy_idle", bus.busy, 0);
    ref_model(po[g], pa[g], pb[g], er, ez, ee);
    @(negedge clk);
    last_m  = g;
    pend[g] = 1'b0;
    drive();
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("alu_opa", bus.alu_opa, pa[g]);
    chk("alu_opb", bus.alu_opb, exp_opb(po[g], pb[g]));
    chk("alu_opcode", bus.alu_opcode, po[g]);
    l_aob = bus.alu_opb;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin @(negedge clk); lat++; end
    l_lat = lat;
    chk("latency", lat, 2);
    chk("rsp_id", bus.rsp_id, g);
    chk("rsp_result", bus.rsp_result, er);
    chk("rsp_zero", bus.rsp_zero, ez);
    chk("rsp_err", bus.rsp_err, ee);
    l_res = bus.rsp_result; l_z = bus.rsp_zero; l_e = bus.rsp_err;
    if (stall > 0) begin
      bus.rsp_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", bus.rsp_valid, 1);
        chk("stall_result", bus.rsp_result, er);
        chk("stall_req_ready", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("done_valid", bus.rsp_valid, 0);
    chk("done_busy", bus.busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = N - 1;
  endtask

  typedef struct {
    int          rid;
    logic [3:0]  op;
    logic [W-1:0] a, b, res, aob;
    logic        z, e;
  } vec_t;

  vec_t vt [10];

  initial begin
    int g;
    vt[0] = '{0, 4'd0, 32'd5,          32'd7,          32'd12,         32'd7,  1'b0, 1'b0};
    vt[1] = '{1, 4'd1, 32'd9,          32'd9,          32'd0,          32'd9,  1'b1, 1'b0};
    vt[2] = '{0, 4'd5, 32'd1,          32'h21,         32'd2,          32'd1,  1'b0, 1'b0};
    vt[3] = '{1, 4'd7, 32'h8000_0000,  32'd31,         32'd1,          32'd31, 1'b0, 1'b0};
    vt[4] = '{0, 4'd6, 32'd3,          32'd4,          32'd0,          32'd4,  1'b1, 1'b1};
    vt[5] = '{1, 4'd2, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  32'h0FF0_FFFF, 1'b0, 1'b0};
    vt[6] = '{0, 4'd4, 32'hAAAA_5555,  32'hAAAA_5555,  32'd0,          32'hAAAA_5555, 1'b1, 1'b0};
    vt[7] = '{1, 4'd8, 32'd1,          32'd1,          32'd0,          32'd1,  1'b1, 1'b1};
    vt[8] = '{0, 4'd3, 32'h100,        32'h3,          32'h103,        32'h3,  1'b0, 1'b0};
    vt[9] = '{1, 4'd5, 32'hFFFF_FFFF,  32'hFFFF_FFE0,  32'hFFFF_FFFF,  32'd0,  1'b0, 1'b0};

    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0; end
    last_m = N - 1;
    bus.rsp_ready = 1'b1;
    drive();
    #1;
    chk("reset_valid", bus.rsp_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_alu_opa", bus.alu_opa, 0);
    chk("reset_result", bus.rsp_result, 0);
    chk("reset_zero", bus.rsp_zero, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one requester at a time.
    for (int i = 0; i < 10; i++) begin
      pend[vt[i].rid] = 1'b1;
      pa[vt[i].rid] = vt[i].a; pb[vt[i].rid] = vt[i].b; po[vt[i].rid] = vt[i].op;
      xact(0, g);
      chk("vec_gnt", g, vt[i].rid);
      chk("vec_result", l_res, vt[i].res);
      chk("vec_zero", l_z, vt[i].z);
      chk("vec_err", l_e, vt[i].e);
      chk("vec_alu_opb", l_aob, vt[i].aob);
      chk("vec_latency", l_lat, 2);
    end

    // Fairness: both always requesting from reset gives 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < N; r++) if (!pend[r]) begin
        pend[r] = 1'b1; pa[r] = 32'(100 + 10*i + r); pb[r] = 32'(r + 1); po[r] = 4'd0;
      end
      xact(0, g);
      chk("fair_order", g, i % 2);
    end
    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    drive();

    // Backpressure for 5 cycles, then reset in RESP.
    do_reset();
    pend[0] = 1'b1; pa[0] = 32'h10; pb[0] = 32'h20; po[0] = 4'd0;
    drive();
    #1;
    chk("bp_req_ready", bus.req_ready, 1);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    pend[0] = 1'b0; pend[1] = 1'b1; pa[1] = 32'h7; pb[1] = 32'h1; po[1] = 4'd1;
    drive();
    @(negedge clk);
    repeat (5) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 32'h30);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_busy", bus.busy, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_alu_opa", bus.alu_opa, 32'h10);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_alu_opa", bus.alu_opa, 0);
    chk("mid_rst_alu_opb", bus.alu_opb, 0);
    chk("mid_rst_alu_op", bus.alu_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    last_m = N - 1;
    pend[0] = 1'b1;
    xact(0, g);
    chk("post_rst_first_gnt", g, 0);
    xact(0, g);

    // Random traffic with random backpressure.
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < N; r++) if (!pend[r] && $urandom_range(0, 1) == 1) begin
        pend[r] = 1'b1;
        po[r] = 4'($urandom_range(0, 15));
        pa[r] = $urandom;
        pb[r] = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
      end
      if (!pend[0] && !pend[1]) begin
        pend[it % N] = 1'b1; po[it % N] = 4'd1; pa[it % N] = $urandom; pb[it % N] = $urandom;
      end
      xact($urandom_range(0, 2), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
